// File: rtl/alu_issue_stage.sv
// ALU issue stage: registers a decoded RV32I instruction, drives the embedded ALU,
// resolves branches/jumps and presents a registered result packet downstream.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7_5,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_rd_we,
  output logic        out_br_taken,
  output logic [31:0] out_br_target,
  output logic        out_illegal
);

  localparam logic [3:0] FnAdd  = 4'b0000, FnSub  = 4'b0001, FnPassB = 4'b0011;
  localparam logic [3:0] FnOr   = 4'b0100, FnAnd  = 4'b0101, FnXor   = 4'b0111;
  localparam logic [3:0] FnSll  = 4'b1000, FnSrl  = 4'b1001, FnSra   = 4'b1010;
  localparam logic [3:0] FnSlli = 4'b0010, FnSrli = 4'b0110, FnSrai  = 4'b1011;
  localparam logic [3:0] FnSlt  = 4'b1101, FnSltu = 4'b1111;

  localparam logic [6:0] OpReg = 7'b0110011, OpImm  = 7'b0010011, OpLui    = 7'b0110111;
  localparam logic [6:0] OpAui = 7'b0010111, OpLoad = 7'b0000011, OpStore  = 7'b0100011;
  localparam logic [6:0] OpBr  = 7'b1100011, OpJal  = 7'b1101111, OpJalr   = 7'b1100111;

  logic        s_valid, s_f7;
  logic [6:0]  s_opcode;
  logic [2:0]  s_funct3;
  logic [31:0] s_rs1, s_rs2, s_imm, s_pc;
  logic        o_load;

  assign o_load   = s_valid & (~out_valid | out_ready);
  assign in_ready = ~s_valid | o_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid  <= 1'b0;
      s_opcode <= '0;
      s_funct3 <= '0;
      s_f7     <= 1'b0;
      s_rs1    <= '0;
      s_rs2    <= '0;
      s_imm    <= '0;
      s_pc     <= '0;
    end else if (in_ready) begin
      s_valid <= in_valid;
      if (in_valid) begin
        s_opcode <= in_opcode;
        s_funct3 <= in_funct3;
        s_f7     <= in_funct7_5;
        s_rs1    <= in_rs1;
        s_rs2    <= in_rs2;
        s_imm    <= in_imm;
        s_pc     <= in_pc;
      end
    end
  end

  logic [3:0]  alufn;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  shamt;

  always_comb begin
    alufn = FnAdd;
    alu_a = s_rs1;
    alu_b = s_rs2;
    shamt = s_imm[4:0];
    unique case (s_opcode)
      OpReg, OpImm: begin
        if (s_opcode == OpImm) alu_b = s_imm;
        unique case (s_funct3)
          3'b000: alufn = (s_opcode == OpReg && s_f7) ? FnSub : FnAdd;
          3'b001: alufn = (s_opcode == OpReg) ? FnSll : FnSlli;
          3'b010: alufn = FnSlt;
          3'b011: alufn = FnSltu;
          3'b100: alufn = FnXor;
          3'b101: begin
            if (s_opcode == OpReg) alufn = s_f7 ? FnSra : FnSrl;
            else                   alufn = s_f7 ? FnSrai : FnSrli;
          end
          3'b110: alufn = FnOr;
          default: alufn = FnAnd;
        endcase
      end
      OpLui: begin
        alufn = FnPassB;
        alu_b = s_imm;
      end
      OpAui: begin
        alu_a = s_pc;
        alu_b = s_imm;
      end
      OpLoad, OpStore, OpJalr: alu_b = s_imm;
      OpBr: alufn = FnSub;
      default: ;
    endcase
  end

  // Embedded combinational ALU; flags come from the shared add/subtract path.
  logic        use_sub, carry, zf, sf, vf, cf;
  logic [31:0] b_eff, sum, alu_r;

  always_comb begin
    use_sub      = (alufn == FnSub) || (alufn == FnSlt) || (alufn == FnSltu);
    b_eff        = use_sub ? ~alu_b : alu_b;
    {carry, sum} = {1'b0, alu_a} + {1'b0, b_eff} + {32'd0, use_sub};
    vf           = (alu_a[31] == b_eff[31]) && (sum[31] != alu_a[31]);
    unique case (alufn)
      FnAdd, FnSub: alu_r = sum;
      FnPassB:      alu_r = alu_b;
      FnOr:         alu_r = alu_a | alu_b;
      FnAnd:        alu_r = alu_a & alu_b;
      FnXor:        alu_r = alu_a ^ alu_b;
      FnSll:        alu_r = alu_a << alu_b[4:0];
      FnSrl:        alu_r = alu_a >> alu_b[4:0];
      FnSra:        alu_r = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      FnSlli:       alu_r = alu_a << shamt;
      FnSrli:       alu_r = alu_a >> shamt;
      FnSrai:       alu_r = $unsigned($signed(alu_a) >>> shamt);
      FnSlt:        alu_r = {31'd0, sum[31] ^ vf};
      FnSltu:       alu_r = {31'd0, ~carry};
      default:      alu_r = '0;
    endcase
    zf = (alu_r == 32'd0);
    sf = alu_r[31];
    cf = carry;
  end

  logic [31:0] pc_plus4, pc_plus_imm, p_result, p_target;
  logic        p_rd_we, p_taken, p_illegal;

  assign pc_plus4    = s_pc + 32'd4;
  assign pc_plus_imm = s_pc + s_imm;

  always_comb begin
    p_result  = alu_r;
    p_rd_we   = 1'b0;
    p_taken   = 1'b0;
    p_target  = '0;
    p_illegal = 1'b0;
    unique case (s_opcode)
      OpReg, OpImm, OpLui, OpAui, OpLoad: p_rd_we = 1'b1;
      OpStore: ;
      OpBr: begin
        p_result = '0;
        p_target = pc_plus_imm;
        unique case (s_funct3)
          3'b000: p_taken = zf;
          3'b001: p_taken = ~zf;
          3'b100: p_taken = sf ^ vf;
          3'b101: p_taken = ~(sf ^ vf);
          3'b110: p_taken = ~cf;
          3'b111: p_taken = cf;
          default: begin
            p_illegal = 1'b1;
            p_target  = '0;
          end
        endcase
      end
      OpJal: begin
        p_taken  = 1'b1;
        p_target = pc_plus_imm;
        p_result = pc_plus4;
        p_rd_we  = 1'b1;
      end
      OpJalr: begin
        if (s_funct3 == 3'b000) begin
          p_taken  = 1'b1;
          p_target = alu_r & ~32'd1;
          p_result = pc_plus4;
          p_rd_we  = 1'b1;
        end else begin
          p_illegal = 1'b1;
          p_result  = '0;
        end
      end
      default: begin
        p_illegal = 1'b1;
        p_result  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd_we     <= 1'b0;
      out_br_taken  <= 1'b0;
      out_br_target <= '0;
      out_illegal   <= 1'b0;
    end else if (o_load) begin
      out_valid     <= 1'b1;
      out_result    <= p_result;
      out_rd_we     <= p_rd_we;
      out_br_taken  <= p_taken;
      out_br_target <= p_target;
      out_illegal   <= p_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Two-register pipeline stage between instruction decode and writeback. It accepts one decoded RV32I instruction per cycle over a valid/ready handshake and translates opcode/funct fields into the ALU's alufn, a, b and shamt inputs. It samples the ALU result and the zf/sf/vf/cf flags, resolves branches and jumps, and presents a registered result packet downstream. It is the driving end of the ALU interface. The ALU is instantiated inside this block and is purely combinational.

## Interface
- No parameters. Data width is fixed at 32 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_opcode  in  7  instr[6:0].
- in_funct3  in  3  instr[14:12].
- in_funct7_5  in  1  instr[30].
- in_rs1, in_rs2  in  32  register operands.
- in_imm  in  32  sign-extended immediate, already formatted for the instruction type.
- in_pc  in  32  instruction address.
- out_valid  out  1  result packet valid.
- out_ready  in  1  downstream accepts the packet.
- out_result  out  32  writeback value or memory address.
- out_rd_we  out  1  result is written to rd.
- out_br_taken  out  1  redirect required.
- out_br_target  out  32  redirect address.
- out_illegal  out  1  unsupported opcode or funct3.

## Operation
- Stage register S holds the accepted instruction fields plus s_valid. Output register O holds the packet plus out_valid.
- o_load = s_valid & (~out_valid | out_ready).
- in_ready = ~s_valid | o_load. This is combinational and gives full throughput, with no bubble under continuous flow.
- The ALU is driven from S. alufn encoding:
  - add 0000, sub 0001, pass-b 0011
  - or 0100, and 0101, xor 0111
  - sll 1000, srl 1001, sra 1010
  - slli 0010, srli 0110, srai 1011
  - slt 1101, sltu 1111
- OP (0110011), a=rs1, b=rs2, by funct3:
  - 000: add, or sub if funct7_5=1.
  - 001 sll; 010 slt; 011 sltu; 100 xor.
  - 101: srl, or sra if funct7_5=1.
  - 110 or; 111 and.
- OP-IMM (0010011), a=rs1, b=imm, shamt=imm[4:0], same funct3 map with these differences:
  - 000 is always add.
  - 001 maps to slli.
  - 101 maps to srli, or srai if funct7_5=1.
- LUI (0110111): pass-b with b=imm.
- AUIPC (0010111): add with a=pc, b=imm.
- LOAD (0000011) and STORE (0100011): add with a=rs1, b=imm. out_result is the address. rd_we=1 for LOAD, 0 for STORE.
- BRANCH (1100011): sub with a=rs1, b=rs2. Taken condition by funct3:
  - 000 BEQ: zf. 001 BNE: ~zf.
  - 100 BLT: sf!=vf. 101 BGE: sf==vf.
  - 110 BLTU: ~cf. 111 BGEU: cf.
  - 010 and 011 are illegal.
  - Target = pc+imm. rd_we=0. out_result=0.
- JAL (1101111): taken=1, target=pc+imm, result=pc+4, rd_we=1.
- JALR (1100111), funct3=000 only: add with a=rs1, b=imm. taken=1, target=(r & ~1), result=pc+4, rd_we=1.
- pc+4 and pc+imm come from a separate adder, not the ALU. Both wrap modulo 2^32.
- Any other opcode or illegal funct3: illegal=1, result=0, rd_we=0, taken=0, target=0.
- For every other instruction: rd_we=1 (OP, OP-IMM, LUI, AUIPC), taken=0, target=0.
- On o_load, O captures the packet computed from S. Otherwise O holds its value; out_valid clears only when out_ready=1 and there is no o_load.

## Timing
- Latency is 2 cycles. An instruction accepted at edge N (in_valid & in_ready) is in S after N and presents out_valid after edge N+1.
- Throughput is 1 instruction per cycle while out_ready=1.
- When out_valid=1 and out_ready=0, O and all out_* are held stable and S holds. in_ready=0 once S is full.
- When out_ready rises, the next edge transfers S to O and a new input is accepted on the same edge.
- Simultaneous accept at input and drain at output on one edge is legal and loses nothing.
- Reset, asynchronous and taking effect immediately, including mid-operation:
  - s_valid=0, out_valid=0.
  - All out_* data outputs are 0.
  - In-flight instructions are discarded.
  - in_ready becomes 1 on the first cycle after reset deasserts.

## Test plan
- ADD then SUB back-to-back, rs1=0x7FFFFFFF, rs2=1, out_ready=1 -> results 0x80000000 then 0x7FFFFFFE on consecutive cycles, rd_we=1, no bubble.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> taken=1, target=0x120. The same operands with BLTU -> taken=0.
- SRAI rs1=0x80000000, imm=0x404 (funct7_5=1), shamt 4 -> 0xF8000000. SRLI with funct7_5=0 -> 0x08000000.
- JALR rs1=0x1003, imm=0, pc=0x40 -> target=0x1002, result=0x44, taken=1.
- Backpressure: hold out_ready=0 for 5 cycles with 3 instructions offered -> out_* stable, in_ready drops after 1 further accept, and all 3 emerge in order once out_ready=1.
- Opcode 0x7F, and BRANCH with funct3=010 -> illegal=1, rd_we=0, taken=0. Assert rst while S and O are full -> out_valid=0 immediately and no packet emerges after release.
